// File: rtl/serial_rx_deframer_if.sv
// Serial receive interface: line input, byte valid/ack handshake and
// sticky error flags between the deframer (slave) and its host (master).
interface serial_rx_deframer_if #(
    parameter int DATA_W = 8
);
    logic              rx_in;
    logic              dsr;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              ack;
    logic              err_clr;
    logic              frame_err;
    logic              overrun_err;

    modport slave (
        input  rx_in, ack, err_clr,
        output dsr, data_out, data_valid, frame_err, overrun_err
    );

    modport master (
        output rx_in, ack, err_clr,
        input  dsr, data_out, data_valid, frame_err, overrun_err
    );
endinterface

// File: rtl/serial_rx_deframer.sv
// serial_rx_deframer: receives 1-start / DATA_W-data (MSB first) / 1-stop
// frames. The start bit is confirmed at its midpoint, and every later bit is
// then sampled one full BIT_PERIOD apart, which keeps each sample mid-bit.
// Optional macro RX_SYNC_EN: adds a 2-flop synchronizer on rx_in
// (+2 clocks latency).
module serial_rx_deframer #(
    parameter int BIT_PERIOD = 106,
    parameter int DATA_W     = 8
) (
    input logic                  clock,
    input logic                  reset,
    serial_rx_deframer_if.slave  bus
);
    localparam int HALF  = BIT_PERIOD / 2;
    localparam int CNT_W = $clog2(BIT_PERIOD);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BIT_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dvalid_q, dvalid_d;
    logic                dsr_q;
    logic                ferr_q, ferr_d;
    logic                oerr_q, oerr_d;
    logic                rx_s;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], bus.rx_in};
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = bus.rx_in;
`endif

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rx_s) state_d = S_START;
            S_START: if (cnt_q == CNT_HALF_M1) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (cnt_q == CNT_LAST && bit_q == BIT_LAST) state_d = S_STOP;
            S_STOP:  if (cnt_q == CNT_LAST) state_d = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: bit timing, shifting, delivery, handshake and error flags.
    always_comb begin
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        ferr_d   = ferr_q;
        oerr_d   = oerr_q;

        // Handshake and clear first, so a delivery or error set below wins.
        if (bus.ack && dvalid_q) dvalid_d = 1'b0;
        if (bus.err_clr) begin
            ferr_d = 1'b0;
            oerr_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            S_START: begin
                if (cnt_q == CNT_HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d = {shift_q[DATA_W-2:0], rx_s};
                    cnt_d   = '0;
                    bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // A held byte may only be replaced when acked this cycle.
                        if (!dvalid_q || bus.ack) begin
                            dout_d   = shift_q;
                            dvalid_d = 1'b1;
                        end else begin
                            oerr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    // Datapath registers; dsr tracks the registered inverse of data_valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            dsr_q    <= 1'b1;
            ferr_q   <= 1'b0;
            oerr_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            dsr_q    <= !dvalid_d;
            ferr_q   <= ferr_d;
            oerr_q   <= oerr_d;
        end
    end

    assign bus.data_out    = dout_q;
    assign bus.data_valid  = dvalid_q;
    assign bus.dsr         = dsr_q;
    assign bus.frame_err   = ferr_q;
    assign bus.overrun_err = oerr_q;
endmodule

// File: doc/serial_rx_deframer.md
Name: serial_rx_deframer

Overview:
Receive-side partner of the b13 serial transmitter. Consumes its 1-start / 8-data (MSB first) / 1-stop serial stream on `rx_in` and rebuilds each byte. The byte is presented on a valid/ack interface to the downstream consumer. Drives `dsr` back to the transmitter as a ready indication, and flags framing and overrun errors.

Parameters:
- BIT_PERIOD, 106, clocks per serial bit. Matches the transmitter: its counter idles 105 cycles, then emits one bit per 106 clocks. Legal range 4..1023.
- DATA_W, 8, data bits per frame. Only 8 is verified.

Ports:
- clock, input, 1, sole clock; rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- rx_in, input, 1, serial line; idle level 1.
- dsr, output, 1, receiver ready: 1 when no unacknowledged byte is held.
- data_out, output, DATA_W, last accepted byte.
- data_valid, output, 1, data_out holds an unacknowledged byte.
- ack, input, 1, consumer takes data_out; single-cycle pulse.
- err_clr, input, 1, clears the sticky error flags.
- frame_err, output, 1, sticky: stop bit sampled 0.
- overrun_err, output, 1, sticky: a frame completed while data_valid=1 and no ack arrived.

Behaviour:
- Reset values:
  - outputs: data_out=0, data_valid=0, dsr=1, frame_err=0, overrun_err=0
  - internal: FSM=IDLE, counter=0, bit index=0, shift reg=0
- Reset mid-frame aborts the frame with no flags set.
- Define HALF = BIT_PERIOD/2, using integer division. Counter width = clog2(BIT_PERIOD).
- FSM states and transitions:
  - IDLE: rx_s (the sampled line) = 0 → START, counter=0.
  - START: counter increments each cycle. At counter==HALF-1:
    - rx_s=1 → IDLE (glitch; no flag).
    - otherwise → DATA, counter=0, bit index=0.
  - DATA: at counter==BIT_PERIOD-1, shift reg = {shift[DATA_W-2:0], rx_s}, counter=0, bit index+1. After DATA_W bits → STOP. The first received bit therefore lands in data_out[7].
  - STOP: at counter==BIT_PERIOD-1, sample rx_s:
    - rx_s=1: deliver the frame (delivery rules below) → IDLE.
    - rx_s=0: set frame_err, discard the byte → BREAK.
  - BREAK: wait for rx_s=1 → IDLE. This prevents a stuck-low line from retriggering.
- Delivery, evaluated in the cycle the stop bit is sampled as 1:
  - data_valid=0, or ack=1 that cycle: data_out ← shift reg, data_valid=1 on the next edge.
  - data_valid=1 and ack=0: new byte dropped, data_out unchanged, overrun_err set.
- Handshake:
  - ack with data_valid=1 clears data_valid on the next edge, unless a delivery happens the same cycle.
  - ack with data_valid=0 is ignored.
- dsr = !data_valid, driven registered alongside data_valid.
- err_clr clears both flags on the next edge. If a set event occurs in the same cycle, the set wins.
- Latency: data_valid rises HALF + (DATA_W+1)×BIT_PERIOD clocks after the first cycle rx_s=0 in IDLE. That is 1007 for the defaults.

Optional Feature:
RX_SYNC_EN
- Defined: rx_in passes through a 2-flop synchronizer, reset to 1, before becoming rx_s. All latencies grow by 2 clocks.
- Undefined: rx_s = rx_in directly, for same-clock use with the transmitter.

Test Plan:
- Reset then idle line (rx_in=1 for 2000 clocks) → data_valid=0, dsr=1, both error flags 0.
- Frame 0xA5 at 106 clk/bit (0,1,0,1,0,0,1,0,1,1) → data_out=0xA5 and data_valid=1 exactly 1007 clocks after the start edge (1009 with RX_SYNC_EN). dsr=0 until ack; ack → data_valid=0 and dsr=1 the next cycle.
- Start pulse low for only 40 clocks → back to IDLE, no data_valid, no flags. A following valid 0x3C frame is received correctly.
- Stop bit driven 0 → frame_err=1, data_valid stays 0. The line is held low 500 clocks then released → a next frame 0x81 is received. err_clr → frame_err=0.
- Two frames 0x11 then 0x22 with no ack → data_out=0x11, overrun_err=1. Repeat with ack pulsed in the 0x22 stop-sample cycle → data_out=0x22, data_valid=1, overrun_err=0.
- Assert reset asynchronously mid-DATA → all outputs return to reset values immediately. After release, the next full frame 0xFF is received correctly.
